lfsr_13bit_checker: RTL and testbench

- Serial PRBS receiver/checker for the 13-bit XNOR LFSR pattern that the team's generator produces.
- Self-synchronises to an incoming bit stream, declares lock, then counts bit errors. Uses a flywheel predictor so each flipped bit is counted once.
- Sits at the receive end of loopback/link test paths and feeds status to lab display and debug logic.

---
 rtl/lfsr_13bit_checker_if.sv | 23 ++
 rtl/lfsr_13bit_checker.sv | 113 +++++++++++
 tb/tb_lfsr_13bit_checker.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_13bit_checker_if.sv
// rtl/lfsr_13bit_checker_if.sv - stream input and status output bundle for the PRBS checker
interface lfsr_13bit_checker_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_bit;
    logic             clr_cnt;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;

    // Source side: drives the received bit stream, observes status
    modport master (
        output in_valid, in_bit, clr_cnt,
        input  locked, err_pulse, err_count
    );

    // Checker side
    modport slave (
        input  in_valid, in_bit, clr_cnt,
        output locked, err_pulse, err_count
    );
endinterface

// File: rtl/lfsr_13bit_checker.sv
// rtl/lfsr_13bit_checker.sv - self-synchronising 13-bit XNOR PRBS checker with flywheel error counting
module lfsr_13bit_checker #(
    parameter int LOCK_CNT = 32,
    parameter int WIN      = 256,
    parameter int LOSS_THR = 8,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lfsr_13bit_checker_if.slave  s_bus
);
    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int WIN_W  = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int WERR_W = $clog2(LOSS_THR + 1);

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             r_state;
    logic [12:0]        r_hist;
    logic [3:0]         r_fill;
    logic [RUN_W-1:0]   r_run;
    logic [WIN_W-1:0]   r_win_cnt;
    logic [WERR_W-1:0]  r_win_err;
    logic               r_err_pulse;
    logic [CNT_W-1:0]   r_err_count;

    logic               w_pred;
    logic               w_miss;
    logic               w_lockup;
    logic [RUN_W-1:0]   w_run_inc;
    logic               w_win_wrap;
    logic [WERR_W-1:0]  w_win_err_next;
    logic               w_count_err;

    // Next bit expected from the last 13 bits of history
    assign w_pred    = ~(r_hist[12] ^ r_hist[3] ^ r_hist[2] ^ r_hist[0]);
    assign w_miss    = s_bus.in_bit ^ w_pred;
    // All-ones is the XNOR lockup state: it predicts 1 forever, so a stuck-high line must not build a run
    assign w_lockup  = (r_hist == 13'h1FFF) && s_bus.in_bit;
    assign w_run_inc = r_run + 1'b1;

    // A miss on the wrap bit opens the new window with a count of one
    assign w_win_wrap     = (r_win_cnt == WIN_W'(WIN - 1));
    assign w_win_err_next = w_win_wrap ? WERR_W'(w_miss) : (r_win_err + WERR_W'(w_miss));

    assign w_count_err = s_bus.in_valid && (r_state == ST_LOCKED) && w_miss;

    // Search/lock state machine with history, run and loss-window tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_SEARCH;
            r_hist    <= '0;
            r_fill    <= '0;
            r_run     <= '0;
            r_win_cnt <= '0;
            r_win_err <= '0;
        end else if (s_bus.in_valid) begin
            case (r_state)
                ST_SEARCH: begin
                    r_hist <= {r_hist[11:0], s_bus.in_bit};
                    if (r_fill < 4'd13) begin
                        r_fill <= r_fill + 4'd1;
                    end else if (w_miss || w_lockup) begin
                        r_run <= '0;
                    end else if (w_run_inc == RUN_W'(LOCK_CNT)) begin
                        r_state   <= ST_LOCKED;
                        r_run     <= '0;
                        r_win_cnt <= '0;
                        r_win_err <= '0;
                    end else begin
                        r_run <= w_run_inc;
                    end
                end
                ST_LOCKED: begin
                    // Flywheel: received bits never enter history, so one flipped bit costs one error
                    r_hist    <= {r_hist[11:0], w_pred};
                    r_win_cnt <= w_win_wrap ? '0 : (r_win_cnt + 1'b1);
                    r_win_err <= w_win_err_next;
                    if (w_miss && (w_win_err_next >= WERR_W'(LOSS_THR))) begin
                        r_state <= ST_SEARCH;
                        r_fill  <= '0;
                        r_run   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_SEARCH;
                end
            endcase
        end
    end

    // Error pulse and saturating error counter; clear has priority over a same-cycle error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_err_pulse <= w_count_err;
            if (s_bus.clr_cnt) begin
                r_err_count <= '0;
            end else if (w_count_err && !(&r_err_count)) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end
    end

    assign s_bus.locked    = (r_state == ST_LOCKED);
    assign s_bus.err_pulse = r_err_pulse;
    assign s_bus.err_count = r_err_count;
endmodule

// File: tb/tb_lfsr_13bit_checker.sv
// tb/tb_lfsr_13bit_checker.sv - directed self-checking bench for lfsr_13bit_checker
module tb_lfsr_13bit_checker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lfsr_13bit_checker_if #(.CNT_W(16)) bus ();

    lfsr_13bit_checker #(
        .LOCK_CNT(32), .WIN(256), .LOSS_THR(8), .CNT_W(16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_bus (bus.slave)
    );

    int          vectors = 0;
    int          miscompares = 0;
    logic [12:0] g_s;
    int          bit_idx;

    // Reference generator: next PRBS bit from a 13-bit XNOR LFSR
    function automatic logic gen();
        logic b;
        b   = ~(g_s[12] ^ g_s[3] ^ g_s[2] ^ g_s[0]);
        g_s = {g_s[11:0], b};
        return b;
    endfunction

    // Drive on the falling edge, return 1 time unit after the sampling edge
    task automatic drive(input logic v, input logic b, input logic c);
        @(negedge clk);
        bus.in_valid = v;
        bus.in_bit   = b;
        bus.clr_cnt  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic flip);
        logic b;
        b = gen();
        drive(1'b1, b ^ flip, 1'b0);
        bit_idx++;
    endtask

    task automatic send_clean(input int n);
        for (int i = 0; i < n; i++) send(1'b0);
    endtask

    // Clean bits up to idx-1, then a flipped bit at idx
    task automatic err_at(input int idx);
        while (bit_idx < idx - 1) send(1'b0);
        send(1'b1);
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_bit   = 1'b0;
        bus.clr_cnt  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        g_s     = 13'h1EE;
        bit_idx = 0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (bus.locked !== 1'b0) begin
            miscompares++; $display("FAIL reset_locked got=%b exp=0", bus.locked);
        end
        vectors++;
        if (bus.err_pulse !== 1'b0) begin
            miscompares++; $display("FAIL reset_err_pulse got=%b exp=0", bus.err_pulse);
        end
        vectors++;
        if (bus.err_count !== 16'd0) begin
            miscompares++; $display("FAIL reset_err_count got=%0d exp=0", bus.err_count);
        end
    endtask

    task automatic test_lock_continuous();
        int early;
        int pulses;
        do_reset();
        early = 0;
        for (int i = 1; i <= 44; i++) begin
            send(1'b0);
            if (bus.locked === 1'b1) early++;
        end
        vectors++;
        if (early != 0) begin
            miscompares++; $display("FAIL cont_early_lock got=%0d exp=0", early);
        end
        send(1'b0);
        vectors++;
        if (bus.locked !== 1'b1) begin
            miscompares++; $display("FAIL cont_lock_at_45 got=%b exp=1", bus.locked);
        end
        pulses = 0;
        for (int i = 0; i < 2000 - 45; i++) begin
            send(1'b0);
            if (bus.err_pulse === 1'b1) pulses++;
        end
        vectors++;
        if (bus.err_count !== 16'd0 || pulses != 0) begin
            miscompares++; $display("FAIL cont_err_count got=%0d pulses=%0d exp=0", bus.err_count, pulses);
        end
        vectors++;
        if (bus.locked !== 1'b1) begin
            miscompares++; $display("FAIL cont_still_locked got=%b exp=1", bus.locked);
        end
    endtask

    task automatic test_lock_gapped();
        int   vc;
        int   cyc;
        logic b;
        logic exp_l;
        do_reset();
        vc  = 0;
        cyc = 0;
        while (vc < 45 && cyc < 1000) begin
            cyc++;
            if ($urandom_range(0, 1) == 1) begin
                b = gen();
                drive(1'b1, b, 1'b0);
                vc++;
            end else begin
                drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
                vectors++;
                if (bus.err_pulse !== 1'b0) begin
                    miscompares++; $display("FAIL gap_idle_pulse cyc=%0d got=%b exp=0", cyc, bus.err_pulse);
                end
            end
            exp_l = (vc >= 45);
            vectors++;
            if (bus.locked !== exp_l) begin
                miscompares++; $display("FAIL gap_locked vc=%0d got=%b exp=%b", vc, bus.locked, exp_l);
            end
        end
        vectors++;
        if (vc < 45) begin
            miscompares++; $display("FAIL gap_timeout valid_bits=%0d exp=45", vc);
        end
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0);
        vectors++;
        if (bus.locked !== 1'b1) begin
            miscompares++; $display("FAIL gap_hold_idle got=%b exp=1", bus.locked);
        end
    endtask

    task automatic test_single_flip();
        int pulses;
        do_reset();
        err_at(500);
        vectors++;
        if (bus.err_pulse !== 1'b1 || bus.err_count !== 16'd1 || bus.locked !== 1'b1) begin
            miscompares++;
            $display("FAIL flip_hit pulse=%b count=%0d locked=%b exp 1/1/1", bus.err_pulse, bus.err_count, bus.locked);
        end
        send(1'b0);
        vectors++;
        if (bus.err_pulse !== 1'b0) begin
            miscompares++; $display("FAIL flip_pulse_width got=%b exp=0", bus.err_pulse);
        end
        pulses = 0;
        for (int i = 0; i < 300; i++) begin
            send(1'b0);
            if (bus.err_pulse === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 0 || bus.err_count !== 16'd1 || bus.locked !== 1'b1) begin
            miscompares++;
            $display("FAIL flip_flywheel pulses=%0d count=%0d locked=%b exp 0/1/1", pulses, bus.err_count, bus.locked);
        end
    endtask

    task automatic test_loss_relock();
        int early;
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            err_at(90 + 10 * k);
            vectors++;
            if (bus.err_count !== 16'(k) || bus.err_pulse !== 1'b1) begin
                miscompares++; $display("FAIL loss_count k=%0d got=%0d pulse=%b exp=%0d/1", k, bus.err_count, bus.err_pulse, k);
            end
            vectors++;
            if (bus.locked !== (k < 8)) begin
                miscompares++; $display("FAIL loss_locked k=%0d got=%b exp=%b", k, bus.locked, (k < 8));
            end
        end
        early = 0;
        for (int i = 1; i <= 44; i++) begin
            send(1'b0);
            if (bus.locked === 1'b1) early++;
        end
        vectors++;
        if (early != 0) begin
            miscompares++; $display("FAIL relock_early got=%0d exp=0", early);
        end
        send(1'b0);
        vectors++;
        if (bus.locked !== 1'b1 || bus.err_count !== 16'd8) begin
            miscompares++; $display("FAIL relock locked=%b count=%0d exp 1/8", bus.locked, bus.err_count);
        end
    endtask

    task automatic test_window_wrap();
        do_reset();
        for (int k = 0; k < 7; k++) err_at(60 + 10 * k);
        err_at(301);
        vectors++;
        if (bus.locked !== 1'b1) begin
            miscompares++; $display("FAIL wrap_bit_new_window locked=%b exp=1", bus.locked);
        end
        for (int k = 0; k < 6; k++) err_at(320 + 10 * k);
        vectors++;
        if (bus.locked !== 1'b1 || bus.err_count !== 16'd14) begin
            miscompares++; $display("FAIL wrap_seven locked=%b count=%0d exp 1/14", bus.locked, bus.err_count);
        end
        err_at(380);
        vectors++;
        if (bus.locked !== 1'b0 || bus.err_count !== 16'd15) begin
            miscompares++; $display("FAIL wrap_eighth locked=%b count=%0d exp 0/15", bus.locked, bus.err_count);
        end
    endtask

    task automatic test_stuck();
        int seen;
        for (int lvl = 1; lvl >= 0; lvl--) begin
            do_reset();
            seen = 0;
            for (int i = 0; i < 1000; i++) begin
                drive(1'b1, 1'(lvl), 1'b0);
                if (bus.locked === 1'b1) seen++;
            end
            vectors++;
            if (seen != 0 || bus.err_count !== 16'd0) begin
                miscompares++; $display("FAIL stuck_%0d locked_cycles=%0d count=%0d exp 0/0", lvl, seen, bus.err_count);
            end
        end
    endtask

    task automatic test_clr_async();
        logic b;
        do_reset();
        for (int k = 0; k < 5; k++) err_at(60 + 10 * k);
        vectors++;
        if (bus.err_count !== 16'd5) begin
            miscompares++; $display("FAIL clr_pre_count got=%0d exp=5", bus.err_count);
        end
        while (bit_idx < 109) send(1'b0);
        b = gen();
        drive(1'b1, ~b, 1'b1);
        bit_idx++;
        vectors++;
        if (bus.err_count !== 16'd0 || bus.err_pulse !== 1'b1 || bus.locked !== 1'b1) begin
            miscompares++;
            $display("FAIL clr_same_cycle count=%0d pulse=%b locked=%b exp 0/1/1", bus.err_count, bus.err_pulse, bus.locked);
        end
        err_at(120);
        vectors++;
        if (bus.err_count !== 16'd1 || bus.err_pulse !== 1'b1) begin
            miscompares++; $display("FAIL clr_after count=%0d pulse=%b exp 1/1", bus.err_count, bus.err_pulse);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.locked !== 1'b0 || bus.err_pulse !== 1'b0 || bus.err_count !== 16'd0) begin
            miscompares++;
            $display("FAIL async_reset locked=%b pulse=%b count=%0d exp 0/0/0", bus.locked, bus.err_pulse, bus.err_count);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lock_continuous();
        test_lock_gapped();
        test_single_flip();
        test_loss_relock();
        test_window_wrap();
        test_stuck();
        test_clr_async();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
